// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage of the pipeline. Holds the program counter, drives
// the instruction memory address straight from the PC register, and loads
// the IF/ID pipeline register with the fetched word, its PC+4 and a kill
// flag. Load-use stalls and taken branches both turn the IF/ID load into a
// bubble (NOP with kill set). A TRAP instruction (opcode 6'h11) halts the
// fetch FSM until reset.
//
// Parameters:
//   RESET_PC            PC value loaded on reset
//
// Ports:
//   clk                 single clock, all state updates on the rising edge
//   reset               synchronous, active-high reset
//   imem_addr           instruction memory address (the PC register)
//   imem_data           instruction word read combinationally at imem_addr
//                       (bit 0 = MSB numbering, opcode in the top 6 bits)
//   stall               load-use bubble request from decode control
//   branch_taken        decode resolved a taken jump/branch
//   branch_target       redirect PC, valid when branch_taken is high
//   if_id_instr         IF/ID instruction register
//   if_id_pc_plus_four  IF/ID PC+4 register
//   if_id_kill          IF/ID kill flag (decode should_be_killed)
//   halted              fetch FSM is in HALTED
//   fetch_count         number of valid IF/ID loads
//   bubble_count        number of stall/branch bubbles
//
// Configuration macro:
//   FETCH_PERF_CNT_EN   when defined, fetch_count and bubble_count are real
//                       wrapping 32-bit counters; otherwise both ports are
//                       tied to zero and no counter registers exist.
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus_four,
    output logic        if_id_kill,
    output logic        halted,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0015;
    localparam logic [5:0]  TRAP_OPCODE = 6'h11;

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pc_plus_four;
    logic         is_trap;
    logic         normal_fetch;
    logic         bubble_insert;

    // Bit 0 is the MSB in the instruction numbering, so opcode [0:5] is the
    // top six bits of the word.
    always_comb begin
        pc_plus_four  = pc + 32'd4;
        is_trap       = (imem_data[31:26] == TRAP_OPCODE);
        normal_fetch  = (state == RUN) && !branch_taken && !stall;
        bubble_insert = (state == RUN) && (branch_taken || stall);
    end

    // The memory address is the PC register itself, so it can only move on
    // a clock edge and never follows the inputs combinationally.
    assign imem_addr = pc;
    assign halted    = (state == HALTED);

    // Fetch FSM, PC and IF/ID register. In RUN a taken branch beats a stall,
    // which beats a normal fetch. A branch squashes whatever was fetched this
    // cycle and redirects to the word-aligned target. A stall keeps the PC so
    // the same address is fetched again next cycle. A TRAP is still passed to
    // decode un-killed; only the fetches after it are frozen. In HALTED the
    // PC stays put and IF/ID keeps receiving bubbles until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= RUN;
            pc                 <= RESET_PC;
            if_id_instr        <= NOP_INSTR;
            if_id_pc_plus_four <= 32'h0000_0000;
            if_id_kill         <= 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (branch_taken) begin
                        pc          <= {branch_target[31:2], 2'b00};
                        if_id_instr <= NOP_INSTR;
                        if_id_kill  <= 1'b1;
                    end else if (stall) begin
                        if_id_instr <= NOP_INSTR;
                        if_id_kill  <= 1'b1;
                    end else begin
                        pc                 <= pc_plus_four;
                        if_id_instr        <= imem_data;
                        if_id_pc_plus_four <= pc_plus_four;
                        if_id_kill         <= 1'b0;
                        if (is_trap) begin
                            state <= HALTED;
                        end
                    end
                end
                HALTED: begin
                    if_id_instr <= NOP_INSTR;
                    if_id_kill  <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q;
    logic [31:0] bubble_count_q;

    // Performance counters. Only bubbles caused by a stall or branch in RUN
    // are counted; reset bubbles and the HALTED filler are not. Both wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q  <= 32'h0000_0000;
            bubble_count_q <= 32'h0000_0000;
        end else begin
            if (normal_fetch) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (bubble_insert) begin
                bubble_count_q <= bubble_count_q + 32'd1;
            end
        end
    end

    assign fetch_count  = fetch_count_q;
    assign bubble_count = bubble_count_q;
`else
    // Counters compiled out: the strobes have no consumer, the ports read 0.
    logic unused_strobes;
    assign unused_strobes = normal_fetch ^ bubble_insert;
    assign fetch_count    = 32'h0000_0000;
    assign bubble_count   = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed, self-checking bench for fetch_stage. A small instruction memory
// model answers imem_addr combinationally; each step drives stall/branch on
// the falling edge and checks every output just after the next rising edge
// against hand-computed values. Counter expectations follow whether
// FETCH_PERF_CNT_EN is defined for this build.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0015;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus_four;
    logic        if_id_kill;
    logic        halted;
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;

    int checks   = 0;
    int failures = 0;

    fetch_stage #(
        .RESET_PC(RESET_PC)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .imem_addr          (imem_addr),
        .imem_data          (imem_data),
        .stall              (stall),
        .branch_taken       (branch_taken),
        .branch_target      (branch_target),
        .if_id_instr        (if_id_instr),
        .if_id_pc_plus_four (if_id_pc_plus_four),
        .if_id_kill         (if_id_kill),
        .halted             (halted),
        .fetch_count        (fetch_count),
        .bubble_count       (bubble_count)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory model: a few fixed words, everything else is a
    // non-TRAP word (opcode 6'h18) tagged with its own address.
    function automatic logic [31:0] imemWord(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: imemWord = 32'h2001_0004;
            32'h0000_0004: imemWord = 32'h2002_0008;
            32'h0000_0030: imemWord = 32'h4400_0000;
            default:       imemWord = {8'h60, addr[23:0]};
        endcase
    endfunction

    always_comb begin
        imem_data = imemWord(imem_addr);
    end

    // Single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of control inputs on the falling edge, then settle just
    // past the following rising edge so outputs are sampled away from it.
    task automatic applyStimulus(input logic rst, input logic stl, input logic br,
                                 input logic [31:0] tgt);
        @(negedge clk);
        reset         = rst;
        stall         = stl;
        branch_taken  = br;
        branch_target = tgt;
        @(posedge clk);
        #1;
    endtask

    // Check the full visible state after a step.
    task automatic checkAll(input string tag, input logic [31:0] exp_addr,
                            input logic [31:0] exp_instr, input logic [31:0] exp_ppf,
                            input logic exp_kill, input logic exp_halted,
                            input logic [31:0] exp_fc, input logic [31:0] exp_bc);
        checkOutput({tag, ".imem_addr"}, imem_addr, exp_addr);
        checkOutput({tag, ".instr"}, if_id_instr, exp_instr);
        checkOutput({tag, ".pc_plus_four"}, if_id_pc_plus_four, exp_ppf);
        checkOutput({tag, ".kill"}, {31'b0, if_id_kill}, {31'b0, exp_kill});
        checkOutput({tag, ".halted"}, {31'b0, halted}, {31'b0, exp_halted});
        checkOutput({tag, ".fetch_count"}, fetch_count, PERF_ON ? exp_fc : 32'h0);
        checkOutput({tag, ".bubble_count"}, bubble_count, PERF_ON ? exp_bc : 32'h0);
    endtask

    initial begin
        reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;

        // Reset with stall and branch both asserted: reset must win.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0400);
        checkAll("reset", RESET_PC, NOP, 32'h0, 1'b1, 1'b0, 0, 0);

        // Two sequential fetches from 0x0 and 0x4.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkAll("fetch0", 32'h4, 32'h2001_0004, 32'h4, 1'b0, 1'b0, 1, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkAll("fetch1", 32'h8, 32'h2002_0008, 32'h8, 1'b0, 1'b0, 2, 0);

        // Branch to an unaligned target: low bits cleared, bubble, ppf held.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0012);
        checkAll("br_0x10", 32'h10, NOP, 32'h8, 1'b1, 1'b0, 2, 1);

        // One-cycle stall at 0x10, then the same PC is fetched.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkAll("stall", 32'h10, NOP, 32'h8, 1'b1, 1'b0, 2, 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkAll("after_stall", 32'h14, 32'h6000_0010, 32'h14, 1'b0, 1'b0, 3, 2);

        // Go to 0x20, then branch and stall together: branch wins.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0020);
        checkAll("br_0x20", 32'h20, NOP, 32'h14, 1'b1, 1'b0, 3, 3);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0103);
        checkAll("br_stall", 32'h100, NOP, 32'h14, 1'b1, 1'b0, 3, 4);

        // PC wrap: fetch at 0xFFFF_FFFC gives PC+4 of zero.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        checkAll("br_top", 32'hFFFF_FFFC, NOP, 32'h14, 1'b1, 1'b0, 3, 5);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkAll("wrap", 32'h0, 32'h60FF_FFFC, 32'h0, 1'b0, 1'b0, 4, 5);

        // TRAP at 0x30 passes to IF/ID un-killed and halts fetch.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0030);
        checkAll("br_0x30", 32'h30, NOP, 32'h0, 1'b1, 1'b0, 4, 6);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkAll("trap", 32'h34, 32'h4400_0000, 32'h34, 1'b0, 1'b1, 5, 6);

        // While halted, branch and stall are ignored and IF/ID gets bubbles.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0200);
        checkAll("halt_br", 32'h34, NOP, 32'h34, 1'b1, 1'b1, 5, 6);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkAll("halt_stall", 32'h34, NOP, 32'h34, 1'b1, 1'b1, 5, 6);

        // Reset out of HALTED (with a branch pending), then resume fetching.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0300);
        checkAll("halt_reset", RESET_PC, NOP, 32'h0, 1'b1, 1'b0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkAll("refetch", 32'h4, 32'h2001_0004, 32'h4, 1'b0, 1'b0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
